// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: arbiter state encoding and the byte-address limit helper shared by the data memory arbiter blocks.
package mem_arb_pkg;
  typedef enum logic [1:0] {
    RUN        = 2'd0,
    DMA_ACCESS = 2'd1,
    DMA_ACK    = 2'd2
  } state_t;
  function automatic int byte_limit(int depth);
    return 4 * depth;
  endfunction
endpackage

// File: rtl/starve_counter.sv
// starve_counter: 4-bit saturating count of contested DMA cycles (inc/clr in, hit out when the limit is one away).
module starve_counter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic hit
);
  logic [3:0] cnt;
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else cnt <= clr ? 4'd0 : (inc && cnt != 4'hf) ? cnt + 4'd1 : cnt;
  assign hit = cnt == 4'(STARVE_LIMIT - 1);
endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares the data RAM between the CPU MEM stage (Cpu*) and a DMA requester (Dma*), driving the RAM port (Mem*).
module data_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NBits        = 32,
  parameter int MEMORY_DEPTH = 512,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             CpuMemRead,
  input  logic             CpuMemWrite,
  input  logic [NBits-1:0] CpuAddress,
  input  logic [NBits-1:0] CpuWriteData,
  output logic [NBits-1:0] CpuReadData,
  output logic             CpuStall,
  input  logic             DmaReq,
  input  logic             DmaWrite,
  input  logic [NBits-1:0] DmaAddress,
  input  logic [NBits-1:0] DmaWriteData,
  output logic             DmaAck,
  output logic             DmaErr,
  output logic [NBits-1:0] DmaReadData,
  output logic             MemRead,
  output logic             MemWrite,
  output logic [NBits-1:0] MemAddress,
  output logic [NBits-1:0] MemWriteData,
  input  logic [NBits-1:0] MemReadData
);
  localparam logic [NBits-1:0] ADDR_LIMIT = NBits'(byte_limit(MEMORY_DEPTH));
  state_t state, state_nxt;
  logic cpu_idle, addr_ok, dma_sel, hit, cnt_inc, cnt_clr;
  assign cpu_idle = !(CpuMemRead || CpuMemWrite);
  assign dma_sel  = state == DMA_ACCESS;
  assign addr_ok  = DmaAddress < ADDR_LIMIT && DmaAddress[1:0] == 2'b00;
  assign cnt_inc  = state == RUN && DmaReq && !cpu_idle;
  // clear wins over inc so the count restarts after every granted slot
  assign cnt_clr  = !DmaReq || (state == RUN && state_nxt == DMA_ACCESS);
  starve_counter #(.STARVE_LIMIT(STARVE_LIMIT)) u_cnt (
    .clk(clk),
    .rst(reset),
    .inc(cnt_inc),
    .clr(cnt_clr),
    .hit(hit)
  );
  always_ff @(posedge clk)
    if (reset) state <= RUN;
    else state <= state_nxt;
  always_comb
    state_nxt = state == RUN ? ((DmaReq && (cpu_idle || hit)) ? DMA_ACCESS : RUN) :
                state == DMA_ACCESS ? DMA_ACK : RUN;
  always_comb begin
    MemRead      = dma_sel ? (!DmaWrite && addr_ok) : CpuMemRead;
    MemWrite     = dma_sel ? (DmaWrite && addr_ok) : CpuMemWrite;
    MemAddress   = dma_sel ? DmaAddress : CpuAddress;
    MemWriteData = dma_sel ? DmaWriteData : CpuWriteData;
    CpuStall     = dma_sel && !cpu_idle;
    CpuReadData  = MemReadData;
  end
  always_ff @(posedge clk)
    if (reset) begin
      DmaAck      <= 1'b0;
      DmaErr      <= 1'b0;
      DmaReadData <= '0;
    end else begin
      DmaAck <= dma_sel;
      if (dma_sel) DmaErr <= !addr_ok;
      if (dma_sel && !DmaWrite) DmaReadData <= MemReadData;
    end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed self-checking bench for data_mem_arbiter with a behavioural RAM.
module tb_data_mem_arbiter;
  logic        clk = 1'b0, reset = 1'b1;
  logic        CpuMemRead = 1'b0, CpuMemWrite = 1'b0;
  logic [31:0] CpuAddress = '0, CpuWriteData = '0, CpuReadData;
  logic        CpuStall;
  logic        DmaReq = 1'b0, DmaWrite = 1'b0;
  logic [31:0] DmaAddress = '0, DmaWriteData = '0;
  logic        DmaAck, DmaErr;
  logic [31:0] DmaReadData;
  logic        MemRead, MemWrite;
  logic [31:0] MemAddress, MemWriteData, MemReadData;
  logic [31:0] ram [512];
  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  assign MemReadData = ram[MemAddress[10:2]];
  always @(posedge clk) if (MemWrite) ram[MemAddress[10:2]] <= MemWriteData;

  data_mem_arbiter #(.NBits(32), .MEMORY_DEPTH(512), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .CpuMemRead(CpuMemRead), .CpuMemWrite(CpuMemWrite),
    .CpuAddress(CpuAddress), .CpuWriteData(CpuWriteData),
    .CpuReadData(CpuReadData), .CpuStall(CpuStall),
    .DmaReq(DmaReq), .DmaWrite(DmaWrite), .DmaAddress(DmaAddress),
    .DmaWriteData(DmaWriteData), .DmaAck(DmaAck), .DmaErr(DmaErr),
    .DmaReadData(DmaReadData),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemAddress(MemAddress),
    .MemWriteData(MemWriteData), .MemReadData(MemReadData)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
    CpuMemWrite = 1'b1; CpuAddress = a; CpuWriteData = d;
    tick;
    CpuMemWrite = 1'b0;
  endtask

  task automatic cpu_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
    CpuMemRead = 1'b1; CpuAddress = a;
    #1 check(tag, CpuReadData, exp);
    CpuMemRead = 1'b0;
  endtask

  logic [31:0] bad_addr [2] = '{32'h800, 32'h6};
  logic        b2b_rd   [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  logic        b2b_ack  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    tick; tick;
    reset = 1'b0;
    #1;
    check("rst_state", 32'(dut.state), 0);
    check("rst_cnt", 32'(dut.u_cnt.cnt), 0);
    check("rst_ack", 32'(DmaAck), 0);
    check("rst_err", 32'(DmaErr), 0);
    check("rst_rdata", DmaReadData, 0);
    check("rst_stall", 32'(CpuStall), 0);
    cpu_write(32'h40, 32'hDEADBEEF);
    cpu_write(32'h0, 32'hA5A5A5A5);
    cpu_write(32'h4, 32'h11112222);
    cpu_write(32'h8, 32'h0);

    // idle DMA read
    DmaReq = 1'b1; DmaWrite = 1'b0; DmaAddress = 32'h40;
    #1 check("idle_c0_rd", 32'(MemRead), 0);
    check("idle_c0_stall", 32'(CpuStall), 0);
    tick;
    check("idle_c1_rd", 32'(MemRead), 1);
    check("idle_c1_addr", MemAddress, 32'h40);
    check("idle_c1_stall", 32'(CpuStall), 0);
    check("idle_c1_ack", 32'(DmaAck), 0);
    tick;
    check("idle_c2_ack", 32'(DmaAck), 1);
    check("idle_c2_data", DmaReadData, 32'hDEADBEEF);
    check("idle_c2_err", 32'(DmaErr), 0);
    check("idle_c2_stall", 32'(CpuStall), 0);
    DmaReq = 1'b0;
    tick;
    check("idle_c3_ack", 32'(DmaAck), 0);

    // contended DMA write under continuous CPU loads
    CpuMemRead = 1'b1; CpuAddress = 32'h0;
    DmaReq = 1'b1; DmaWrite = 1'b1; DmaAddress = 32'h8; DmaWriteData = 32'h12345678;
    for (int i = 0; i < 4; i++) begin
      #1 check("cont_served_stall", 32'(CpuStall), 0);
      check("cont_served_data", CpuReadData, 32'hA5A5A5A5);
      tick;
    end
    check("cont_stall", 32'(CpuStall), 1);
    check("cont_wr", 32'(MemWrite), 1);
    check("cont_addr", MemAddress, 32'h8);
    check("cont_wdata", MemWriteData, 32'h12345678);
    tick;
    check("cont_ack_stall", 32'(CpuStall), 0);
    check("cont_ack", 32'(DmaAck), 1);
    check("cont_err", 32'(DmaErr), 0);
    DmaReq = 1'b0; CpuAddress = 32'h8;
    #1 check("cont_cpu_load", CpuReadData, 32'h12345678);
    tick;
    CpuMemRead = 1'b0;

    // bad DMA addresses: out of range, then misaligned
    for (int i = 0; i < 2; i++) begin
      DmaReq = 1'b1; DmaWrite = 1'b1; DmaAddress = bad_addr[i]; DmaWriteData = 32'hBAD0BAD0;
      tick;
      check("bad_rd", 32'(MemRead), 0);
      check("bad_wr", 32'(MemWrite), 0);
      tick;
      check("bad_ack", 32'(DmaAck), 1);
      check("bad_err", 32'(DmaErr), 1);
      DmaReq = 1'b0;
      tick;
    end
    cpu_read("bad_ram0", 32'h0, 32'hA5A5A5A5);
    cpu_read("bad_ram1", 32'h4, 32'h11112222);

    // same-cycle CPU write and DMA read
    CpuMemWrite = 1'b1; CpuAddress = 32'h20; CpuWriteData = 32'h55;
    DmaReq = 1'b1; DmaWrite = 1'b0; DmaAddress = 32'h20;
    #1 check("same_c0_stall", 32'(CpuStall), 0);
    check("same_c0_wr", 32'(MemWrite), 1);
    check("same_c0_addr", MemAddress, 32'h20);
    tick;
    CpuMemWrite = 1'b0;
    #1 check("same_c1_rd", 32'(MemRead), 0);
    tick;
    check("same_c2_rd", 32'(MemRead), 1);
    check("same_c2_addr", MemAddress, 32'h20);
    tick;
    check("same_c3_ack", 32'(DmaAck), 1);
    check("same_c3_data", DmaReadData, 32'h55);
    DmaReq = 1'b0;
    tick;

    // reset during DMA_ACCESS, request held
    DmaReq = 1'b1; DmaWrite = 1'b0; DmaAddress = 32'h40;
    tick;
    check("rmid_c1_rd", 32'(MemRead), 1);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    #1 check("rmid_state", 32'(dut.state), 0);
    check("rmid_cnt", 32'(dut.u_cnt.cnt), 0);
    check("rmid_ack", 32'(DmaAck), 0);
    check("rmid_rdata", DmaReadData, 0);
    tick;
    check("rmid_c3_rd", 32'(MemRead), 1);
    tick;
    check("rmid_c4_ack", 32'(DmaAck), 1);
    check("rmid_c4_data", DmaReadData, 32'hDEADBEEF);
    DmaReq = 1'b0;
    tick;

    // back-to-back DMA reads with DmaReq held through DmaAck
    DmaReq = 1'b1; DmaWrite = 1'b0; DmaAddress = 32'h40;
    for (int i = 0; i < 6; i++) begin
      #1 check($sformatf("b2b_rd%0d", i), 32'(MemRead), 32'(b2b_rd[i]));
      check($sformatf("b2b_ack%0d", i), 32'(DmaAck), 32'(b2b_ack[i]));
      if (i == 5) DmaReq = 1'b0;
      tick;
    end
    check("b2b_data", DmaReadData, 32'hDEADBEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
